// File: rtl/tristate_bus_responder_if.sv
// Handshake and status signals between the bus initiator and the responder.
// The shared data lines stay a plain inout port on the responder.
interface tristate_bus_responder_if;
  logic req;
  logic rw;
  logic ack;
  logic err;
  logic bus_oe;
  logic busy;

  modport master (
    output req,
    output rw,
    input  ack,
    input  err,
    input  bus_oe,
    input  busy
  );

  modport slave (
    input  req,
    input  rw,
    output ack,
    output err,
    output bus_oe,
    output busy
  );
endinterface

// File: rtl/tristate_bus_responder.sv
// Register-file responder on a half-duplex tri-state bus: captures writes and
// drives read data back for one cycle after a one-cycle turnaround.
module tristate_bus_responder #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tristate_bus_responder_if.slave  bus_if,
  inout  wire  [W-1:0]             bus_data
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WDATA   = 3'd1,
    ST_WACK    = 3'd2,
    ST_TURN    = 3'd3,
    ST_RDRIVE  = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   addr_r;
  logic            oor_r;
  logic [W-1:0]    rd_q_r;
  logic [W-1:0]    mem_r [DEPTH];
  logic            ack_r;
  logic            err_r;
  logic            oe_r;
  logic            busy_r;
  logic            oor_s;
  logic            ack_nxt_s;

  // Full bus value is compared so that high addresses are flagged, not aliased.
  assign oor_s = ({1'b0, bus_data} >= (W+1)'(DEPTH));

  assign bus_data      = oe_r ? rd_q_r : {W{1'bz}};
  assign bus_if.ack    = ack_r;
  assign bus_if.err    = err_r;
  assign bus_if.bus_oe = oe_r;
  assign bus_if.busy   = busy_r;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus_if.req) begin
          state_nxt_s = bus_if.rw ? ST_TURN : ST_WDATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (bus_if.req) begin
          state_nxt_s = ST_WACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WACK:   state_nxt_s = ST_RELEASE;
      ST_TURN: begin
        if (bus_if.req) begin
          state_nxt_s = ST_RDRIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RDRIVE: state_nxt_s = ST_RELEASE;
      ST_RELEASE: begin
        if (bus_if.req) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  assign ack_nxt_s = (state_nxt_s == ST_WACK) || (state_nxt_s == ST_RDRIVE);

  // State register and outputs registered from the next state, so every
  // output is a flop that async reset clears immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      oe_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= ack_nxt_s && oor_r;
      oe_r    <= (state_nxt_s == ST_RDRIVE);
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Address capture and read-data staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      oor_r  <= 1'b0;
      rd_q_r <= '0;
    end else begin
      if ((state_r == ST_IDLE) && bus_if.req) begin
        addr_r <= bus_data[AW-1:0];
        oor_r  <= oor_s;
      end
      if ((state_r == ST_TURN) && bus_if.req) begin
        rd_q_r <= oor_r ? {W{1'b0}} : mem_r[addr_r];
      end
    end
  end

  // Register file; out-of-range writes are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if ((state_r == ST_WDATA) && bus_if.req && !oor_r) begin
        mem_r[addr_r] <= bus_data;
      end
    end
  end

endmodule

// File: tb/tb_tristate_bus_responder.sv
// Randomized bench for tristate_bus_responder against a transaction-level
// register-file model.
module tb_tristate_bus_responder;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] tb_drv;
  logic         tb_oe;
  wire  [W-1:0] bus_data;
  logic [W-1:0] model [DEPTH];
  int           tests_run;
  int           fail_cnt;

  tristate_bus_responder_if bif ();

  assign bus_data = tb_oe ? tb_drv : {W{1'bz}};

  tristate_bus_responder #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_if   (bif.slave),
    .bus_data (bus_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d,
                          input bit abort_it, input int hold);
    int   acks;
    logic exp_oor;
    exp_oor = (int'(a) >= DEPTH);
    @(negedge clk);
    bif.req = 1'b1; bif.rw = 1'b0; tb_drv = a; tb_oe = 1'b1;
    @(negedge clk);
    check_eq("wr_busy_data", 32'(bif.busy), 32'd1);
    check_eq("wr_oe_data", 32'(bif.bus_oe), 32'd0);
    check_eq("wr_ack_early", 32'(bif.ack), 32'd0);
    if (abort_it) begin
      bif.req = 1'b0; tb_oe = 1'b0;
      @(negedge clk);
      check_eq("wr_abort_ack", 32'(bif.ack), 32'd0);
      check_eq("wr_abort_busy", 32'(bif.busy), 32'd0);
    end else begin
      tb_drv = d;
      @(negedge clk);
      check_eq("wr_ack", 32'(bif.ack), 32'd1);
      check_eq("wr_err", 32'(bif.err), 32'(exp_oor));
      check_eq("wr_oe_ack", 32'(bif.bus_oe), 32'd0);
      tb_oe = 1'b0;
      acks = 0;
      for (int i = 0; i <= hold; i++) begin
        @(negedge clk);
        acks += int'(bif.ack);
        check_eq("wr_busy_release", 32'(bif.busy), 32'd1);
      end
      check_eq("wr_extra_acks", 32'(acks), 32'd0);
      bif.req = 1'b0;
      @(negedge clk);
      check_eq("wr_idle_busy", 32'(bif.busy), 32'd0);
      if (!exp_oor) model[a[3:0]] = d;
    end
  endtask

  task automatic do_read(input logic [W-1:0] a, input bit abort_it);
    logic         exp_oor;
    logic [W-1:0] exp_d;
    exp_oor = (int'(a) >= DEPTH);
    exp_d   = exp_oor ? '0 : model[a[3:0]];
    @(negedge clk);
    bif.req = 1'b1; bif.rw = 1'b1; tb_drv = a; tb_oe = 1'b1;
    @(negedge clk);
    tb_oe = 1'b0;
    check_eq("rd_turn_oe", 32'(bif.bus_oe), 32'd0);
    check_eq("rd_turn_ack", 32'(bif.ack), 32'd0);
    if (abort_it) begin
      bif.req = 1'b0;
      @(negedge clk);
      check_eq("rd_abort_oe", 32'(bif.bus_oe), 32'd0);
      check_eq("rd_abort_ack", 32'(bif.ack), 32'd0);
      check_eq("rd_abort_busy", 32'(bif.busy), 32'd0);
    end else begin
      @(negedge clk);
      check_eq("rd_oe", 32'(bif.bus_oe), 32'd1);
      check_eq("rd_ack", 32'(bif.ack), 32'd1);
      check_eq("rd_err", 32'(bif.err), 32'(exp_oor));
      check_eq("rd_data", 32'(bus_data), 32'(exp_d));
      @(negedge clk);
      check_eq("rd_release_oe", 32'(bif.bus_oe), 32'd0);
      check_eq("rd_release_ack", 32'(bif.ack), 32'd0);
      bif.req = 1'b0;
      @(negedge clk);
      check_eq("rd_idle_busy", 32'(bif.busy), 32'd0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_ack", 32'(bif.ack), 32'd0);
    check_eq("rst_err", 32'(bif.err), 32'd0);
    check_eq("rst_oe", 32'(bif.bus_oe), 32'd0);
    check_eq("rst_busy", 32'(bif.busy), 32'd0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] d;
    int           op;
    tests_run = 0;
    fail_cnt  = 0;
    bif.req = 1'b0; bif.rw = 1'b0;
    tb_drv = '0; tb_oe = 1'b0;
    rst_n = 1'b1;
    clear_model();
    #2;
    apply_reset();

    do_read(8'd7, 1'b0);
    do_write(8'd3, 8'hA5, 1'b0, 0);
    do_read(8'd3, 1'b0);

    do_write(8'h20, 8'h3C, 1'b0, 0);
    do_read(8'h20, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_read(8'(i), 1'b0);

    do_write(8'd5, 8'h5A, 1'b1, 0);
    do_read(8'd5, 1'b0);
    do_read(8'd3, 1'b1);
    do_write(8'd6, 8'h66, 1'b0, 0);
    do_read(8'd6, 1'b0);

    do_write(8'd9, 8'h99, 1'b0, 10);
    do_read(8'd9, 1'b0);

    // Reset asserted while the read data is on the bus.
    @(negedge clk);
    bif.req = 1'b1; bif.rw = 1'b1; tb_drv = 8'd3; tb_oe = 1'b1;
    @(negedge clk);
    tb_oe = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rd_oe", 32'(bif.bus_oe), 32'd1);
    check_eq("mid_rd_data", 32'(bus_data), 32'hA5);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_oe", 32'(bif.bus_oe), 32'd0);
    check_eq("mid_rst_ack", 32'(bif.ack), 32'd0);
    check_eq("mid_rst_busy", 32'(bif.busy), 32'd0);
    bif.req = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    do_read(8'd3, 1'b0);

    for (int n = 0; n < 60; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1, 2: do_write(a, d, 1'b0, int'($urandom_range(0, 2)));
        3:       do_write(a, d, 1'b1, 0);
        4:       do_read(a, 1'b0);
        default: do_read(a, 1'b1);
      endcase
    end
    for (int i = 0; i < DEPTH; i++) do_read(8'(i), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/tristate_bus_responder.md
# tristate_bus_responder

Register-file responder on a shared, half-duplex, tri-state data bus. An external initiator places a command and address on the bus. The responder either captures write data into its internal register file or turns the bus around and drives read data back through its own tri-state driver. It is the far end of the bus whose line drivers are our tri-state buffers.

## Interface
Parameters:
- `W`, 8: bus and register width in bits.
- `DEPTH`, 16: number of registers; must be ≥ 2 and ≤ 2^W.
- `AW`, clog2(`DEPTH`): address width; derived, not user-set.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  initiator transaction request; held high for the whole transaction.
- `rw`  in  1  1 = read, 0 = write; sampled with the address.
- `bus_data`  inout  `W`  shared bus; driven by this block only when `bus_oe`=1, else `'bz`.
- `ack`  out  1  one-cycle transaction acknowledge.
- `err`  out  1  high together with `ack` when the address was out of range.
- `bus_oe`  out  1  responder drive-enable, exported for observation.
- `busy`  out  1  high in every state except IDLE.

## Operation
States:
- IDLE: `bus_oe`=0, `ack`=0.
  - At an edge with `req`=1: latch `addr` = `bus_data`[AW-1:0] and `rw`.
  - Latch `oor` = (full `bus_data` value ≥ `DEPTH`).
  - Go to WDATA if `rw`=0, else TURN.
- WDATA: the initiator drives write data during this cycle.
  - At the edge, if `req`=1: write `mem[addr]` <= `bus_data` unless `oor`, then go to WACK.
  - If `req`=0: abort. No write; go to IDLE.
- WACK: `ack`=1, `err`=`oor`; then go to RELEASE.
- TURN: one turnaround cycle with the bus undriven by both sides.
  - At the edge, if `req`=1: load `rd_q` <= (`oor` ? 0 : `mem[addr]`), then go to RDRIVE.
  - If `req`=0: go to IDLE. The responder never drives.
- RDRIVE: `bus_oe`=1, `bus_data`=`rd_q`, `ack`=1, `err`=`oor`; then go to RELEASE.
- RELEASE: `bus_oe`=0, `ack`=0. Stay until `req`=0 is sampled, then go to IDLE. A held `req` never starts a second transaction.

Rules:
- `ack`, `err` and `bus_oe` are decoded from registered state only; no combinational path from inputs.
- `bus_oe` is high only in RDRIVE. The bus is never driven in IDLE, WDATA, TURN or RELEASE.
- An out-of-range address is not a protocol error: the handshake completes normally, writes are discarded, reads return 0.

## Timing
- Edge E0 samples `req`=1 in IDLE.
- Write: data is sampled at E1. `ack` is high for E1–E2. RELEASE is entered at E2.
- Read: E0–E1 is the turnaround. Data is driven and `ack` is high for E1–E2; the initiator samples at E2. The bus is released at E2.
- Both directions have the same `ack` timing: `ack` is high for exactly one cycle, one cycle after the sample edge.
- Minimum transaction spacing is 4 cycles: `req` must be low at ≥ 1 edge in RELEASE before the next request.
- Reset (`rst_n`=0, at any time, including mid-RDRIVE):
  - Immediately: state=IDLE, `bus_oe`=0, `bus_data`=`'bz`, `ack`=0, `err`=0, `busy`=0.
  - All `mem` entries = 0, `rd_q`=0, `addr`=0.
  - After release, the first edge with `req`=1 starts a fresh transaction.
- Address wrap: none. Addresses ≥ `DEPTH` are flagged, never aliased modulo `DEPTH`.

## Test plan
- Reset then idle: `rst_n`=0 → `ack`=0, `err`=0, `bus_oe`=0, `busy`=0, `bus_data`=z. Reading any address after reset returns 0x00.
- Write/read: write 0xA5 to addr 3, then read addr 3.
  - Write: `ack` is high for 1 cycle, one cycle after the data edge, with `err`=0.
  - Read: the bus is z during turnaround, then 0xA5 with `bus_oe`=`ack`=1 for exactly one cycle, then z.
- Out of range (`DEPTH`=16): write 0x3C to addr 0x20, then read addr 0x20. Both complete with `ack`=1 and `err`=1. The read returns 0x00, and no in-range register changes.
- Abort: drop `req` during WDATA → no write and no `ack`. Drop `req` during TURN → `bus_oe` stays 0 and no `ack`. The next transaction proceeds normally.
- Held request: keep `req`=1 for 10 cycles after `ack` → exactly one `ack` and `busy`=1 throughout. After `req` drops, a new request is accepted.
- Reset mid-read: assert `rst_n`=0 during RDRIVE → `bus_oe` and `ack` fall immediately without waiting for a clock edge. A subsequent read of that address returns 0x00.
